riscv_dmem_resp: RTL and testbench

RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

---
 rtl/riscv_dmem_resp_pkg.sv | 27 ++
 rtl/riscv_dmem_rsp_fifo.sv | 69 ++++++
 rtl/riscv_dmem_resp.sv | 79 +++++++
 tb/tb_riscv_dmem_resp.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_resp_pkg.sv
// Shared types and encodings for the data-memory responder and its response queue.
package riscv_dmem_resp_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // One queued response: load data (zero for stores/faults) plus fault flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

  // Alignment fault for a given access size and byte offset; the reserved size always faults.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_dmem_rsp_fifo.sv
// In-order response queue between the data array and the core's response channel.
// Push is ignored when full and pop is ignored when empty, so callers may drive raw handshakes.
module riscv_dmem_rsp_fifo
  import riscv_dmem_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  rsp_entry_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output rsp_entry_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  rsp_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head is forced to zero when empty so the response outputs read zero through reset.
  assign head_o = empty_o ? '0 : mem_q[rptr_q];

  // Pointer advance with explicit wrap (depth need not be a power of two) and occupancy update.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    if (do_pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue control state; reset discards everything queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; unreset because occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/riscv_dmem_resp.sv
// Single-cycle data memory for a RISC-V core: fault checks, byte-masked stores,
// combinational load read captured into an in-order response queue.
module riscv_dmem_resp
  import riscv_dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RSP_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          rdy_q;
  logic          accept;
  logic          out_of_range;
  logic          fault;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          fifo_full, fifo_empty;
  rsp_entry_t    push_entry, head_entry;

  assign accept       = req_valid && req_ready;
  assign word_idx     = req_addr[AW+1:2];
  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign fault        = out_of_range || size_misaligned(req_size, req_addr[1:0]);
  assign rd_word      = out_of_range ? '0 : mem_q[word_idx];

  assign push_entry.rdata = (req_we || fault) ? '0 : rd_word;
  assign push_entry.err   = fault;

  // Ready depends only on registered state, never on rsp_ready.
  assign req_ready = rdy_q && !fifo_full;
  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = head_entry.rdata;
  assign rsp_err   = head_entry.err;

  // Holds req_ready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  // Byte-masked store into the data array; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (req_wmask[k]) mem_q[word_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  riscv_dmem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (rsp_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_entry)
  );

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Scoreboard bench for riscv_dmem_resp: expected responses are queued at acceptance
// and checked in order as the responder hands them back.
module tb_riscv_dmem_resp;
  import riscv_dmem_resp_pkg::*;

  localparam int DW = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run = 0;
  int failures  = 0;

  rsp_entry_t  sb[$];
  rsp_entry_t  mon_exp;
  logic [31:0] model [DW];

  riscv_dmem_resp #(.DEPTH_WORDS(DW), .RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic bit tb_fault(input logic [31:0] a, input logic [1:0] s);
    if (a[31:2] >= DW) return 1'b1;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && a[0]) return 1'b1;
    if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Response checker: every pop handshake is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
      end else begin
        mon_exp = sb.pop_front();
        if (rsp_rdata !== mon_exp.rdata || rsp_err !== mon_exp.err) begin
          failures++;
          $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_exp.rdata, mon_exp.err);
        end
      end
    end
  end

  // Drives one request, waits for acceptance, records the expected response and updates the model.
  task automatic send(input logic [31:0] a, input logic we, input logic [1:0] s,
                      input logic [31:0] wd, input logic [3:0] wm);
    bit         ok;
    bit         f;
    rsp_entry_t e;
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_size  = s;
    req_wdata = wd;
    req_wmask = wm;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      failures++;
      $display("FAIL send_timeout addr=%h: req_ready=%b, required 1", a, req_ready);
    end else begin
      f = tb_fault(a, s);
      e.err   = f;
      e.rdata = (we || f) ? 32'h0 : model[a[11:2]];
      sb.push_back(e);
      if (we && !f) begin
        for (int k = 0; k < 4; k++)
          if (wm[k]) model[a[11:2]][8*k +: 8] = wd[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      tests_run++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_early: req_ready=%b, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_edge: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_full_word();
    rsp_ready = 1'b1;
    send(32'h10, 1'b1, SZ_WORD, 32'hDEADBEEF, 4'hF);
    wait_drain();
    send(32'h10, 1'b0, SZ_WORD, 32'h0, 4'h0);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL load_latency: valid=%b rdata=%h err=%b, required 1 deadbeef 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    wait_drain();
  endtask

  task automatic test_byte_store();
    rsp_ready = 1'b1;
    send(32'h12, 1'b1, SZ_BYTE, 32'h55555555, 4'h4);
    wait_drain();
    send(32'h10, 1'b0, SZ_WORD, 32'h0, 4'h0);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE55BEEF) begin
      failures++;
      $display("FAIL byte_store: valid=%b rdata=%h, required 1 de55beef", rsp_valid, rsp_rdata);
    end
    wait_drain();
  endtask

  task automatic test_misalign();
    rsp_ready = 1'b1;
    send(32'h13, 1'b1, SZ_HALF, 32'hFFFFFFFF, 4'hF);
    send(32'h11, 1'b1, SZ_WORD, 32'hFFFFFFFF, 4'hF);
    send(32'h12, 1'b0, SZ_WORD, 32'h0, 4'h0);
    send(32'h10, 1'b0, 2'd3, 32'h0, 4'h0);
    send(32'h11, 1'b0, SZ_HALF, 32'h0, 4'h0);
    wait_drain();
    send(32'h10, 1'b0, SZ_WORD, 32'h0, 4'h0);
    tests_run++;
    if (rsp_rdata !== 32'hDE55BEEF || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_unchanged: rdata=%h err=%b, required de55beef 0", rsp_rdata, rsp_err);
    end
    wait_drain();
  endtask

  task automatic test_range();
    rsp_ready = 1'b1;
    send(32'hFFC, 1'b1, SZ_WORD, 32'hA5A5A5A5, 4'hF);
    send(32'hFFC, 1'b0, SZ_WORD, 32'h0, 4'h0);
    send(DW * 4, 1'b0, SZ_WORD, 32'h0, 4'h0);
    send(DW * 4, 1'b1, SZ_WORD, 32'h12345678, 4'hF);
    send(32'hFFFFFFFC, 1'b0, SZ_BYTE, 32'h0, 4'h0);
    wait_drain();
  endtask

  task automatic test_stream();
    logic [31:0] addrs [6];
    logic        wes   [6];
    logic [1:0]  szs   [6];
    logic [31:0] wds   [6];
    logic [3:0]  wms   [6];
    addrs = '{32'h30, 32'h30, 32'h22, 32'h20, 32'h13, 32'h31};
    wes   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    szs   = '{SZ_WORD, SZ_WORD, SZ_HALF, SZ_WORD, SZ_BYTE, SZ_BYTE};
    wds   = '{32'h01234567, 32'hFFFFFFFF, 32'h11111111, 32'h0, 32'h0, 32'h0};
    wms   = '{4'hF, 4'hF, 4'hC, 4'h0, 4'hF, 4'h0};
    rsp_ready = 1'b1;
    send(32'h20, 1'b1, SZ_WORD, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 6; i++) begin
      send(addrs[i], wes[i], szs[i], wds[i], wms[i]);
      tests_run++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready step %0d: req_ready=%b, required 1", i, req_ready);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    send(32'h10, 1'b0, SZ_WORD, 32'h0, 4'h0);
    send(32'h40, 1'b1, SZ_WORD, 32'h0BADF00D, 4'hF);
    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE55BEEF) begin
      failures++;
      $display("FAIL full_state: ready=%b valid=%b rdata=%h, required 0 1 de55beef",
               req_ready, rsp_valid, rsp_rdata);
    end
    fork
      send(32'h40, 1'b0, SZ_WORD, 32'h0, 4'h0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk);
          #1;
          tests_run++;
          if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE55BEEF || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cycle %0d: ready=%b valid=%b rdata=%h err=%b, required 0 1 de55beef 0",
                     i, req_ready, rsp_valid, rsp_rdata, rsp_err);
          end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop: req_ready=%b, required 1", req_ready);
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    send(32'h10, 1'b0, SZ_WORD, 32'h0, 4'h0);
    send(32'h20, 1'b0, SZ_WORD, 32'h0, 4'h0);
    tests_run++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_full: valid=%b ready=%b, required 1 0", rsp_valid, req_ready);
    end
    #2;
    rstn = 1'b0;
    #1;
    sb.delete();
    tests_run++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b ready=%b rdata=%h err=%b, required 0 0 0 0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release_early: req_ready=%b, required 0", req_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release_edge: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    send(32'h10, 1'b0, SZ_WORD, 32'h0, 4'h0);
    tests_run++;
    if (rsp_rdata !== 32'hDE55BEEF || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL data_after_reset: rdata=%h err=%b, required de55beef 0", rsp_rdata, rsp_err);
    end
    send(32'h30, 1'b0, SZ_WORD, 32'h0, 4'h0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_word();
    test_byte_store();
    test_misalign();
    test_range();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
